// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NUM_REQ valid/ready requesters.
// One arbitration cycle per grant, then up to MAX_BURST writes; a full fifo stalls the owner without losing the grant.
module fifo_wr_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int WIDTH     = 8,
  parameter  int MAX_BURST = 4,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     full,
  output logic                     write_en,
  output logic [WIDTH-1:0]         data_in,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy
);

  localparam int              CNTW      = $clog2(MAX_BURST + 1);
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(MAX_BURST - 1);
  localparam logic [IDW-1:0]  LAST_ID   = IDW'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0]  grant_nxt;
  logic [IDW-1:0]  rr_owner;
  logic [IDW-1:0]  owner_inc;
  logic [CNTW-1:0] burst_cnt, burst_cnt_nxt;
  logic            owner_valid;
  logic            transfer;

  // First valid requester searching upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    logic found;
    int   idx;
    found    = 1'b0;
    idx      = 0;
    rr_owner = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        rr_owner = IDW'(idx);
      end
    end
  end

  assign owner_valid = req_valid[grant_id];
  assign owner_inc   = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      grant_id  <= grant_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    grant_nxt     = grant_id;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_nxt     = BURST;
          grant_nxt     = rr_owner;
          burst_cnt_nxt = '0;
        end
      end
      BURST: begin
        if (transfer) burst_cnt_nxt = burst_cnt + 1'b1;
        // A stalled owner keeps the grant; only a dropped valid or the last beat rotates.
        if (!owner_valid || (transfer && burst_cnt == LAST_BEAT)) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = owner_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == BURST && !rst && !full) req_ready[grant_id] = 1'b1;
    transfer = owner_valid & req_ready[grant_id];
    write_en = transfer;
    data_in  = req_data[int'(grant_id)*WIDTH +: WIDTH];
    busy     = (state == BURST);
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) write_en |-> !full);
  a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));
  a_we_is_xfer: assert property (@(posedge clk) write_en == |(req_valid & req_ready));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: transaction-level requester/fifo model, per-cycle expectations and write scoreboard.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ = 4, WIDTH = 8, MAX_BURST = 4, DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     full;
  logic                     write_en;
  logic [WIDTH-1:0]         data_in;
  logic [1:0]               grant_id;
  logic                     busy;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .full(full), .write_en(write_en), .data_in(data_in), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ready;
    logic       we;
    logic [1:0] grant;
    logic       busy;
    bit         known;
  } exp_t;

  exp_t       cyc_q[$];
  logic [7:0] wr_q[$];
  logic [7:0] dut_log[$];
  logic [7:0] rq[NUM_REQ][$];
  logic [7:0] fifo_q[$];

  int n_checks = 0, n_err = 0, wr_count = 0;
  logic [3:0] en;
  bit force_full, rst_req;
  int rd_mode;  // 0: reader idle, 1: random reads, 2: read every cycle

  // Reference state: owner -1 means nobody holds the port.
  int m_owner = -1, m_beats = 0, m_ptr = 0, m_grant = 0;
  bit m_known = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      check("req_ready", 32'(req_ready), 32'(e.ready));
      check("write_en", 32'(write_en), 32'(e.we));
      if (e.known) begin
        check("grant_id", 32'(grant_id), 32'(e.grant));
        check("busy", 32'(busy), 32'(e.busy));
      end
    end
    if (write_en) begin
      wr_count++;
      dut_log.push_back(data_in);
      if (wr_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_write: got data %0h with no write expected", data_in);
      end else begin
        check("data_in", 32'(data_in), 32'(wr_q.pop_front()));
      end
    end
  end

  task automatic apply_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]         = en[i] && (rq[i].size() > 0);
      req_data[i*WIDTH +: WIDTH] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
    end
    full = force_full || (fifo_q.size() >= DEPTH);
    rst  = rst_req;
  endtask

  // One clock: predict this cycle from current inputs, then advance across the edge.
  task automatic step();
    exp_t       e;
    int         n_owner, n_beats, n_ptr, n_grant;
    bit         xfer, found, rd;
    logic [3:0] rdy;
    logic [7:0] wdat;
    rdy = '0; xfer = 0; found = 0; wdat = '0;
    n_owner = m_owner; n_beats = m_beats; n_ptr = m_ptr; n_grant = m_grant;
    if (rst) begin
      n_owner = -1; n_beats = 0; n_ptr = 0; n_grant = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int j = (m_ptr + k) % NUM_REQ;
        if (!found && req_valid[j]) begin
          found = 1; n_owner = j; n_grant = j; n_beats = 0;
        end
      end
    end else begin
      if (!full) rdy[m_owner] = 1'b1;
      xfer = req_valid[m_owner] && !full;
      if (xfer) begin
        wdat = req_data[m_owner*WIDTH +: WIDTH];
        wr_q.push_back(wdat);
        n_beats = m_beats + 1;
      end
      if (!req_valid[m_owner] || (xfer && n_beats == MAX_BURST)) begin
        n_owner = -1;
        n_ptr   = (m_owner + 1) % NUM_REQ;
      end
    end
    e.ready = rdy; e.we = xfer; e.grant = 2'(m_grant); e.busy = (m_owner >= 0); e.known = m_known;
    cyc_q.push_back(e);
    rd = (rd_mode == 2) || (rd_mode == 1 && $urandom_range(1, 0) == 1);
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (xfer) begin
      void'(rq[m_owner].pop_front());
      fifo_q.push_back(wdat);
    end
    if (rst) m_known = 1;
    m_owner = n_owner; m_beats = n_beats; m_ptr = n_ptr; m_grant = n_grant;
    apply_inputs();
  endtask

  task automatic do_reset();
    rst_req = 1; apply_inputs(); step();
    rst_req = 0; apply_inputs();
  endtask

  task automatic drain(input string name);
    int  n = 0;
    bit  pending;
    en = '1; force_full = 0; apply_inputs();
    pending = 1;
    while (pending && n < 400) begin
      pending = (m_owner >= 0);
      for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() > 0) pending = 1;
      if (pending) begin step(); n++; end
    end
    check({name, "_drain_timeout"}, 32'(n < 400), 32'd1);
  endtask

  initial begin
    int base, c0, n;
    logic [7:0] e2e_exp [8];
    logic [7:0] s4_exp [5];
    e2e_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
    s4_exp  = '{8'h40, 8'h50, 8'h51, 8'h52, 8'h53};
    en = '1; force_full = 0; rst_req = 1; rd_mode = 2;
    req_valid = '0; req_data = '0; full = 0; rst = 1;
    @(posedge clk); #1;
    apply_inputs();
    step(); step();
    rst_req = 0; apply_inputs();

    // Single requester burst A1..A4
    base = dut_log.size();
    for (int i = 0; i < 4; i++) rq[0].push_back(8'(8'hA1 + i));
    apply_inputs();
    drain("s1");
    check("s1_count", 32'(dut_log.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) check("s1_data", 32'(dut_log[base+i]), 32'(8'hA1 + i));

    // All requesters continuously valid: 16 writes per 20 cycles
    do_reset();
    for (int i = 0; i < NUM_REQ; i++)
      for (int w = 0; w < 8; w++) rq[i].push_back(8'((i << 4) | w));
    apply_inputs();
    c0 = wr_count;
    repeat (20) step();
    check("s2_writes_20cyc", 32'(wr_count - c0), 32'd16);
    drain("s2");

    // Owner 2 stalled by full after its 2nd write
    do_reset();
    for (int w = 0; w < 4; w++) rq[2].push_back(8'(8'h30 + w));
    apply_inputs();
    c0 = wr_count;
    repeat (3) step();
    check("s3_pre_stall_writes", 32'(wr_count - c0), 32'd2);
    force_full = 1; apply_inputs();
    repeat (3) begin
      step();
      check("s3_stall_grant", 32'(grant_id), 32'd2);
    end
    check("s3_stall_writes", 32'(wr_count - c0), 32'd2);
    force_full = 0; apply_inputs();
    drain("s3");
    check("s3_total_writes", 32'(wr_count - c0), 32'd4);

    // Owner 0 drops valid after one write; requester 3 takes over
    do_reset();
    base = dut_log.size();
    rq[0].push_back(8'h40);
    for (int w = 0; w < 4; w++) rq[3].push_back(8'(8'h50 + w));
    apply_inputs();
    drain("s4");
    for (int i = 0; i < 5; i++) check("s4_order", 32'(dut_log[base+i]), 32'(s4_exp[i]));

    // Reset during the 3rd beat, then 4'b1010 goes to requester 1
    do_reset();
    for (int w = 0; w < 4; w++) rq[0].push_back(8'(8'h60 + w));
    en = 4'b0001; apply_inputs();
    repeat (3) step();
    rst_req = 1; apply_inputs();
    step();
    rst_req = 0;
    check("s5_busy_after_rst", 32'(busy), 32'd0);
    check("s5_grant_after_rst", 32'(grant_id), 32'd0);
    rq[1].push_back(8'h70);
    rq[3].push_back(8'h80);
    en = 4'b1010; apply_inputs();
    step();
    check("s5_grant", 32'(grant_id), 32'd1);
    drain("s5");

    // End-to-end with a depth-4 fifo and an idle reader
    n = 0;
    while (fifo_q.size() > 0 && n < 20) begin step(); n++; end
    rd_mode = 0;
    do_reset();
    base = dut_log.size();
    for (int w = 0; w < 4; w++) begin
      rq[0].push_back(8'(8'h10 + w));
      rq[1].push_back(8'(8'h20 + w));
    end
    apply_inputs();
    c0 = wr_count;
    repeat (15) step();
    check("e2e_writes_until_full", 32'(wr_count - c0), 32'd4);
    rd_mode = 2;
    drain("e2e");
    for (int i = 0; i < 8; i++) check("e2e_order", 32'(dut_log[base+i]), 32'(e2e_exp[i]));

    // Randomised traffic, valid withdrawal and fifo backpressure
    rd_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      int r = $urandom_range(NUM_REQ - 1, 0);
      if ($urandom_range(2, 0) != 0 && rq[r].size() < 6) rq[r].push_back(8'($urandom));
      if ($urandom_range(7, 0) == 0) begin
        int b = $urandom_range(NUM_REQ - 1, 0);
        en[b] = ~en[b];
      end
      if ($urandom_range(199, 0) == 0) rst_req = 1;
      apply_inputs();
      step();
      rst_req = 0;
    end
    apply_inputs();
    drain("random");
    @(negedge clk); #1;
    check("scoreboard_empty", 32'(wr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares the write side of one `fifo` instance (DEPTH/WIDTH parameterised) between NUM_REQ requesters.
- Each requester presents data with a valid/ready handshake.
- The arbiter grants one owner at a time for a bounded burst, drives `write_en`/`data_in` into the FIFO and respects `full`.
- Sits directly in front of `fifo`; the read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, data width; must match the fifo WIDTH.
- MAX_BURST, 4, maximum writes per grant before ownership rotates (>=1).

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  reset: one clock; reset is synchronous and active-high.
- req_valid  input  NUM_REQ  bit i: requester i has a word.
- req_data  input  NUM_REQ*WIDTH  requester i data at [i*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  bit i: word from requester i accepted this cycle when valid is also high.
- full  input  1  from fifo.full.
- write_en  output  1  to fifo.write_en.
- data_in  output  WIDTH  to fifo.data_in.
- grant_id  output  $clog2(NUM_REQ)  current owner index (registered).
- busy  output  1  high while in BURST.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, busy=0.
  - Combinational outputs resolve to req_ready=0, write_en=0.
  - data_in=req_data[grant_id]; its value is don't-care when write_en=0.
  - Reset mid-burst aborts the burst; the word presented in that cycle is not written.
- FSM has two states, IDLE and BURST.
- IDLE:
  - req_ready=0; no transfers.
  - If any req_valid: owner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - grant_id<=owner, burst_cnt<=0, go to BURST.
  - Otherwise stay in IDLE.
  - Arbitration costs exactly one cycle: the first write is at the earliest one cycle after req_valid rises.
- BURST:
  - req_ready[grant_id] = ~full; all other req_ready bits are 0.
  - Transfer = req_valid[grant_id] & req_ready[grant_id].
  - write_en = transfer; data_in = req_data[grant_id]. Both are combinational from registered grant_id.
  - On transfer: burst_cnt<=burst_cnt+1.
  - Exit to IDLE, with rr_ptr<=(grant_id+1) mod NUM_REQ, when either:
    - a transfer occurs with burst_cnt==MAX_BURST-1, or
    - req_valid[grant_id]==0 (no transfer that cycle).
- full=1 in BURST:
  - no transfer and burst_cnt is held; stay in BURST while owner valid stays high (stall does not forfeit the grant).
  - Owner dropping valid while full still exits.
- Requests arriving in IDLE from several requesters in the same cycle are resolved purely by rr_ptr order.
- Fairness bound: with every requester continuously valid and full=0, each requester gets MAX_BURST writes per (MAX_BURST+1)*NUM_REQ cycles.
- Wrap-around: rr_ptr wraps from NUM_REQ-1 to 0. grant_id never exceeds NUM_REQ-1.
- Protocol rule on requesters: data must be stable while valid=1 and ready=0. The arbiter never writes when full=1, so fifo overflow is impossible.
- Assertions:
  - write_en -> !full
  - $onehot0(req_ready)
  - write_en == |(req_valid & req_ready)

Test Plan:
- Single requester: rst high 2 cycles, then req_valid=4'b0001 with data 8'hA1..A4 held per handshake, full=0.
  - First write_en one cycle after valid.
  - Four consecutive writes A1,A2,A3,A4 in 4 cycles.
  - One IDLE cycle, then rr_ptr=1.
- All four requesters valid continuously, MAX_BURST=4, full=0.
  - grant_id sequence 0,1,2,3,0.
  - Exactly 4 writes per grant, one idle cycle between grants.
  - 16 writes in 20 cycles.
- full asserted for 3 cycles mid-burst after the 2nd write of owner 2.
  - write_en=0 and req_ready=0 during those cycles; grant_id stays 2.
  - Remaining 2 writes follow when full drops; burst_cnt totals 4.
- Owner drops valid after 1 write while requester 3 is valid.
  - Exit to IDLE next cycle; rr_ptr=owner+1.
  - Requester 3 is granted and writes starting 2 cycles after the drop.
- rst asserted during the 3rd beat of a burst.
  - That beat is not written (write_en=0 in the reset cycle).
  - Next cycle: state IDLE, rr_ptr=0, busy=0.
  - With req_valid=4'b1010, grant goes to requester 1.
- End-to-end with the fifo instance (DEPTH=4):
  - Requesters 0 and 1 each send 4 words (0x10..0x13, 0x20..0x23) while the reader is idle.
  - full rises after 4 writes and no write occurs while full.
  - After draining, data_out order is 0x10,0x11,0x12,0x13, then 0x20..0x23 once space frees.
